// File: rtl/sim_status_collector_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sim_status_pkg: state encoding, summary word layout and popcount helper
// Rev 1.0
// ---------------------------------------------------------------------------
package sim_status_pkg;

  localparam int unsigned MAX_NCH     = 16;
  // Summary word: fail count at the bottom, timeout flag directly above it
  localparam int unsigned SUM_CNT_LSB = 0;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_FINAL = 2'd2
  } state_e;

  function automatic int unsigned sum_cnt_w(input int unsigned nch);
    return $clog2(nch + 1);
  endfunction

  function automatic logic [4:0] popcount16(input logic [MAX_NCH-1:0] v);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAX_NCH; i++) begin
      n = n + {4'd0, v[i]};
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sim_status_collector_watchdog.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sim_watchdog: saturating cycle counter, flags the last allowed enabled cycle
// Rev 1.0
// ---------------------------------------------------------------------------
module sim_watchdog #(
  parameter  int unsigned TIMEOUT_CYC = 9600,
  localparam int unsigned CNT_W       = $clog2(TIMEOUT_CYC + 1)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [CNT_W-1:0] C_SAT  = CNT_W'(TIMEOUT_CYC);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != C_SAT)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = i_en && (cnt_q == C_LAST);

endmodule
`default_nettype wire

// File: rtl/sim_status_collector.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sim_status_collector: latches per-channel done/success/report with a
// watchdog, drains reports one per cycle, then holds the aggregate verdict.
// Rev 1.0
// ---------------------------------------------------------------------------
module sim_status_collector
  import sim_status_pkg::*;
#(
  parameter  int unsigned NCH         = 4,
  parameter  int unsigned REPORT_W    = 32,
  parameter  int unsigned TIMEOUT_CYC = 9600,
  localparam int unsigned IDX_W       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic [NCH-1:0]          ch_enable,
  input  logic [NCH-1:0]          ch_done,
  input  logic [NCH-1:0]          ch_success,
  input  logic [NCH*REPORT_W-1:0] ch_report,
  output logic [NCH-1:0]          done_mask,
  output logic [NCH-1:0]          fail_mask,
  output logic                    timeout,
  output logic                    report_valid,
  output logic [IDX_W-1:0]        report_idx,
  output logic [REPORT_W-1:0]     sim_report,
  output logic                    sim_done,
  output logic                    sim_success
);

  localparam int unsigned      PC_W       = sum_cnt_w(NCH);
  localparam logic [IDX_W-1:0] C_LAST_IDX = IDX_W'(NCH - 1);

  state_e                state_q, state_d;
  logic [NCH-1:0]        done_mask_q, done_mask_d;
  logic [NCH-1:0]        fail_mask_q, fail_mask_d;
  logic                  timeout_q, timeout_d;
  logic [REPORT_W-1:0]   rep_q [NCH];
  logic [REPORT_W-1:0]   rep_d [NCH];
  logic                  report_valid_q, report_valid_d;
  logic [IDX_W-1:0]      report_idx_q, report_idx_d;
  logic [REPORT_W-1:0]   sim_report_q, sim_report_d;
  logic                  sim_done_q, sim_done_d;
  logic                  sim_success_q, sim_success_d;

  logic [NCH-1:0]        w_capture;
  logic                  w_all_done_next;
  logic                  w_expire;
  logic [4:0]            w_fail_cnt;
  logic [IDX_W-1:0]      w_next_idx;

  sim_watchdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_watchdog (
    .clk      (refclk),
    .rst_n    (rst_n),
    .i_clr    (state_q != ST_RUN),
    .i_en     (state_q == ST_RUN),
    .o_expire (w_expire)
  );

  assign w_capture       = (state_q == ST_RUN) ? (ch_enable & ch_done & ~done_mask_q) : '0;
  assign w_all_done_next = &(done_mask_q | (ch_done & ch_enable) | ~ch_enable);
  assign w_fail_cnt      = popcount16(MAX_NCH'(fail_mask_q));
  assign w_next_idx      = report_idx_q + IDX_W'(1);

  always_comb begin
    state_d        = state_q;
    done_mask_d    = done_mask_q | w_capture;
    fail_mask_d    = fail_mask_q;
    timeout_d      = timeout_q;
    rep_d          = rep_q;
    report_valid_d = report_valid_q;
    report_idx_d   = report_idx_q;
    sim_report_d   = sim_report_q;
    sim_done_d     = sim_done_q;
    sim_success_d  = sim_success_q;

    for (int i = 0; i < NCH; i++) begin
      if (w_capture[i]) begin
        fail_mask_d[i] = ~ch_success[i];
        rep_d[i]       = ch_report[i*REPORT_W +: REPORT_W];
      end
    end

    case (state_q)
      ST_RUN: begin
        if (w_all_done_next || w_expire) begin
          state_d        = ST_DRAIN;
          report_valid_d = 1'b1;
          report_idx_d   = '0;
          // Slot 0 may be captured on this very edge, so use its next value
          sim_report_d   = rep_d[0];
          if (!w_all_done_next) begin
            timeout_d   = 1'b1;
            fail_mask_d = fail_mask_d | (ch_enable & ~done_mask_d);
          end
        end
      end
      ST_DRAIN: begin
        if (report_idx_q == C_LAST_IDX) begin
          state_d        = ST_FINAL;
          report_valid_d = 1'b0;
          report_idx_d   = '0;
          sim_done_d     = 1'b1;
          sim_success_d  = (fail_mask_q == '0) && !timeout_q;
          sim_report_d   = (REPORT_W'(w_fail_cnt) << SUM_CNT_LSB) |
                           (REPORT_W'(timeout_q) << (SUM_CNT_LSB + PC_W));
        end else begin
          report_idx_d = w_next_idx;
          sim_report_d = rep_q[w_next_idx];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_RUN;
      done_mask_q    <= '0;
      fail_mask_q    <= '0;
      timeout_q      <= 1'b0;
      for (int i = 0; i < NCH; i++) begin
        rep_q[i] <= '0;
      end
      report_valid_q <= 1'b0;
      report_idx_q   <= '0;
      sim_report_q   <= '0;
      sim_done_q     <= 1'b0;
      sim_success_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      done_mask_q    <= done_mask_d;
      fail_mask_q    <= fail_mask_d;
      timeout_q      <= timeout_d;
      rep_q          <= rep_d;
      report_valid_q <= report_valid_d;
      report_idx_q   <= report_idx_d;
      sim_report_q   <= sim_report_d;
      sim_done_q     <= sim_done_d;
      sim_success_q  <= sim_success_d;
    end
  end

  assign done_mask    = done_mask_q;
  assign fail_mask    = fail_mask_q;
  assign timeout      = timeout_q;
  assign report_valid = report_valid_q;
  assign report_idx   = report_idx_q;
  assign sim_report   = sim_report_q;
  assign sim_done     = sim_done_q;
  assign sim_success  = sim_success_q;

endmodule
`default_nettype wire
